// File: rtl/exmem_pipe_if.sv
// EX/MEM pipeline-register bus: execute-stage inputs, memory-stage outputs and the
// data-cache request handshake. master = the pipe register, slave = core/cache side.
interface exmem_pipe_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              ihit;
    logic              dhit;
    logic              flush;
    logic              ex_RegWEN;
    logic              ex_dREN;
    logic              ex_dWEN;
    logic [1:0]        ex_MemtoReg;
    logic [REG_AW-1:0] ex_wsel;
    logic [WORD_W-1:0] ex_aluout;
    logic [WORD_W-1:0] ex_storedata;
    logic [WORD_W-1:0] ex_npc;
    logic              ex_halt;
    logic [WORD_W-1:0] dmemload;

    logic              mem_RegWEN;
    logic [1:0]        mem_MemtoReg;
    logic [REG_AW-1:0] mem_wsel;
    logic [WORD_W-1:0] mem_aluout;
    logic [WORD_W-1:0] mem_npc;
    logic              mem_halt;
    logic [WORD_W-1:0] mem_dload;
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              stall_req;

    modport master (
        input  ihit, dhit, flush, ex_RegWEN, ex_dREN, ex_dWEN, ex_MemtoReg, ex_wsel,
               ex_aluout, ex_storedata, ex_npc, ex_halt, dmemload,
        output mem_RegWEN, mem_MemtoReg, mem_wsel, mem_aluout, mem_npc, mem_halt,
               mem_dload, dmemREN, dmemWEN, dmemaddr, dmemstore, stall_req
    );

    modport slave (
        output ihit, dhit, flush, ex_RegWEN, ex_dREN, ex_dWEN, ex_MemtoReg, ex_wsel,
               ex_aluout, ex_storedata, ex_npc, ex_halt, dmemload,
        input  mem_RegWEN, mem_MemtoReg, mem_wsel, mem_aluout, mem_npc, mem_halt,
               mem_dload, dmemREN, dmemWEN, dmemaddr, dmemstore, stall_req
    );
endinterface

// File: rtl/exmem_pipe.sv
// EX/MEM pipeline register with data-memory request FSM, flush and halt freeze.
// Optional stall/bubble performance counters when EXMEM_PERF_EN is defined.
module exmem_pipe #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic        CLK,
    input  logic        nRST,
    exmem_pipe_if.master bus
`ifdef EXMEM_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic              regwen_q, dren_q, dwen_q, halt_q;
    logic [1:0]        memtoreg_q;
    logic [REG_AW-1:0] wsel_q;
    logic [WORD_W-1:0] aluout_q, storedata_q, npc_q, dload_q;

    logic busy, stall, advance, next_mem, is_load, capture;

    assign busy     = (state_q == BUSY) & ~halt_q;
    assign stall    = busy & ~bus.dhit;
    assign advance  = bus.ihit & ~stall & ~halt_q;
    assign next_mem = ~bus.flush & (bus.ex_dREN | bus.ex_dWEN);
    // dREN together with dWEN is a store
    assign is_load  = dren_q & ~dwen_q;
    assign capture  = busy & bus.dhit & is_load;

    always_comb begin
        state_d = state_q;
        if (!halt_q) begin
            case (state_q)
                IDLE, DONE: if (advance) state_d = next_mem ? BUSY : IDLE;
                BUSY: begin
                    if (bus.dhit) begin
                        if (advance) state_d = next_mem ? BUSY : IDLE;
                        else         state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            regwen_q    <= 1'b0;
            dren_q      <= 1'b0;
            dwen_q      <= 1'b0;
            halt_q      <= 1'b0;
            memtoreg_q  <= '0;
            wsel_q      <= '0;
            aluout_q    <= '0;
            storedata_q <= '0;
            npc_q       <= '0;
            dload_q     <= '0;
        end else begin
            state_q <= state_d;
            if (advance) begin
                if (bus.flush) begin
                    regwen_q    <= 1'b0;
                    dren_q      <= 1'b0;
                    dwen_q      <= 1'b0;
                    halt_q      <= 1'b0;
                    memtoreg_q  <= '0;
                    wsel_q      <= '0;
                    aluout_q    <= '0;
                    storedata_q <= '0;
                    npc_q       <= '0;
                end else begin
                    regwen_q    <= bus.ex_RegWEN;
                    dren_q      <= bus.ex_dREN;
                    dwen_q      <= bus.ex_dWEN;
                    halt_q      <= bus.ex_halt;
                    memtoreg_q  <= bus.ex_MemtoReg;
                    wsel_q      <= bus.ex_wsel;
                    aluout_q    <= bus.ex_aluout;
                    storedata_q <= bus.ex_storedata;
                    npc_q       <= bus.ex_npc;
                end
            end
            if (capture) dload_q <= bus.dmemload;
        end
    end

    assign bus.mem_RegWEN   = regwen_q;
    assign bus.mem_MemtoReg = memtoreg_q;
    assign bus.mem_wsel     = wsel_q;
    assign bus.mem_aluout   = aluout_q;
    assign bus.mem_npc      = npc_q;
    assign bus.mem_halt     = halt_q;
    assign bus.mem_dload    = dload_q;
    assign bus.dmemREN      = busy & is_load;
    assign bus.dmemWEN      = busy & dwen_q;
    assign bus.dmemaddr     = aluout_q;
    assign bus.dmemstore    = storedata_q;
    assign bus.stall_req    = stall;

`ifdef EXMEM_PERF_EN
    logic [31:0] stall_cnt_q, bubble_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (!halt_q) begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (advance && bus.flush && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_exmem_pipe.sv
// Bench for exmem_pipe: directed scenarios plus random traffic, all outputs compared
// every cycle against a transaction-level model (latched op + outstanding-access flag).
module tb_exmem_pipe;
    localparam int unsigned W = 32;
    localparam int unsigned A = 5;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    exmem_pipe_if #(.WORD_W(W), .REG_AW(A)) bus ();

`ifdef EXMEM_PERF_EN
    logic [31:0] stall_cycles, bubble_count;
    exmem_pipe #(.WORD_W(W), .REG_AW(A)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count)
    );
`else
    exmem_pipe #(.WORD_W(W), .REG_AW(A)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
`endif

    typedef struct packed {
        logic        regwen;
        logic        dren;
        logic        dwen;
        logic [1:0]  m2r;
        logic [4:0]  wsel;
        logic [31:0] alu;
        logic [31:0] store;
        logic [31:0] npc;
        logic        halt;
    } op_t;

    // Reference model: the op held in MEM, its load result, and whether its access is open
    op_t         m;
    logic [31:0] m_dload;
    bit          pend;
    logic [31:0] m_stalls, m_bubbles;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic exp_stall();
        return pend && !bus.dhit && !m.halt;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m = '0; m_dload = '0; pend = 0; m_stalls = '0; m_bubbles = '0;
        end else begin
            logic st, adv;
            st  = exp_stall();
            adv = bus.ihit && !st && !m.halt;
            if (!m.halt && st && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
            if (adv && bus.flush && m_bubbles != 32'hFFFF_FFFF) m_bubbles = m_bubbles + 1;
            if (pend && bus.dhit && !m.halt) begin
                if (m.dren && !m.dwen) m_dload = bus.dmemload;
                pend = 0;
            end
            if (adv) begin
                if (bus.flush) m = '0;
                else m = '{regwen: bus.ex_RegWEN, dren: bus.ex_dREN, dwen: bus.ex_dWEN,
                           m2r: bus.ex_MemtoReg, wsel: bus.ex_wsel, alu: bus.ex_aluout,
                           store: bus.ex_storedata, npc: bus.ex_npc, halt: bus.ex_halt};
                pend = m.dren || m.dwen;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("mem_RegWEN",   32'(bus.mem_RegWEN),   32'(m.regwen));
        chk("mem_MemtoReg", 32'(bus.mem_MemtoReg), 32'(m.m2r));
        chk("mem_wsel",     32'(bus.mem_wsel),     32'(m.wsel));
        chk("mem_aluout",   bus.mem_aluout,        m.alu);
        chk("mem_npc",      bus.mem_npc,           m.npc);
        chk("mem_halt",     32'(bus.mem_halt),     32'(m.halt));
        chk("mem_dload",    bus.mem_dload,         m_dload);
        chk("dmemREN",      32'(bus.dmemREN),      32'(pend && m.dren && !m.dwen && !m.halt));
        chk("dmemWEN",      32'(bus.dmemWEN),      32'(pend && m.dwen && !m.halt));
        chk("dmemaddr",     bus.dmemaddr,          m.alu);
        chk("dmemstore",    bus.dmemstore,         m.store);
        chk("stall_req",    32'(bus.stall_req),    32'(exp_stall()));
`ifdef EXMEM_PERF_EN
        chk("stall_cycles", stall_cycles,          m_stalls);
        chk("bubble_count", bubble_count,          m_bubbles);
`endif
    endtask

    function automatic op_t mk(input logic rw, input logic rd, input logic wr, input logic h,
                               input logic [31:0] alu, input logic [4:0] ws);
        op_t o;
        o = '{regwen: rw, dren: rd, dwen: wr, m2r: {rd, 1'b0}, wsel: ws, alu: alu,
              store: alu ^ 32'hA5A5_5A5A, npc: alu + 32'd4, halt: h};
        return o;
    endfunction

    function automatic op_t rand_op(input bit allow_halt);
        op_t o;
        int unsigned k;
        k = $urandom_range(0, 7);
        o = '{regwen: 1'($urandom), dren: (k == 0 || k == 1 || k == 3),
              dwen: (k == 2 || k == 3), m2r: 2'($urandom), wsel: 5'($urandom),
              alu: $urandom, store: $urandom, npc: $urandom,
              halt: allow_halt && ($urandom_range(0, 149) == 0)};
        return o;
    endfunction

    task automatic drive(input logic ih, input logic dh, input logic fl, input op_t ex,
                         input logic [31:0] ld);
        @(negedge CLK);
        bus.ihit = ih; bus.dhit = dh; bus.flush = fl; bus.dmemload = ld;
        bus.ex_RegWEN = ex.regwen; bus.ex_dREN = ex.dren; bus.ex_dWEN = ex.dwen;
        bus.ex_MemtoReg = ex.m2r; bus.ex_wsel = ex.wsel; bus.ex_aluout = ex.alu;
        bus.ex_storedata = ex.store; bus.ex_npc = ex.npc; bus.ex_halt = ex.halt;
        #1 check_all();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        bus.ihit = 0; bus.dhit = 0; bus.flush = 0; bus.dmemload = '0;
        bus.ex_RegWEN = 0; bus.ex_dREN = 0; bus.ex_dWEN = 0; bus.ex_MemtoReg = '0;
        bus.ex_wsel = '0; bus.ex_aluout = '0; bus.ex_storedata = '0; bus.ex_npc = '0;
        bus.ex_halt = 0;
        #1 check_all();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        op_t nop;
        logic [31:0] hold_alu;
        nop = '0;

        do_reset();
        chk("reset mem_aluout", bus.mem_aluout, 32'h0);
        chk("reset stall_req", 32'(bus.stall_req), 32'h0);

        // ALU op
        drive(1, 0, 0, mk(1, 0, 0, 0, 32'h1234, 5'd5), '0);
        drive(0, 0, 0, nop, '0);
        chk("alu mem_aluout", bus.mem_aluout, 32'h1234);
        chk("alu mem_wsel", 32'(bus.mem_wsel), 32'd5);
        chk("alu dmemREN", 32'(bus.dmemREN), 32'd0);
        chk("alu stall_req", 32'(bus.stall_req), 32'd0);

        // Load answered on the third cycle
        drive(1, 0, 0, mk(1, 1, 0, 0, 32'h100, 5'd7), '0);
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, mk(1, 0, 0, 0, 32'h999, 5'd9), 32'hDEAD_BEEF);
            chk("load dmemREN", 32'(bus.dmemREN), 32'd1);
            chk("load stall_req", 32'(bus.stall_req), 32'd1);
            chk("load addr held", bus.dmemaddr, 32'h100);
        end
        drive(0, 1, 0, nop, 32'hDEAD_BEEF);
        drive(0, 0, 0, nop, '0);
        chk("load mem_dload", bus.mem_dload, 32'hDEAD_BEEF);
        chk("load dmemREN drop", 32'(bus.dmemREN), 32'd0);
        chk("load aluout held", bus.mem_aluout, 32'h100);

        // Store then load, dhit and ihit together
        drive(1, 0, 0, mk(0, 0, 1, 0, 32'h200, 5'd0), '0);
        drive(1, 1, 0, mk(1, 1, 0, 0, 32'h300, 5'd3), '0);
        chk("b2b dmemWEN", 32'(bus.dmemWEN), 32'd1);
        drive(0, 1, 0, nop, 32'h0BAD_F00D);
        chk("b2b dmemWEN drop", 32'(bus.dmemWEN), 32'd0);
        chk("b2b dmemREN rise", 32'(bus.dmemREN), 32'd1);
        chk("b2b dmemaddr", bus.dmemaddr, 32'h300);

        // Flush with and without advance
        drive(1, 0, 1, mk(1, 0, 1, 0, 32'h444, 5'd4), '0);
        drive(1, 0, 0, mk(1, 0, 0, 0, 32'h55, 5'd6), '0);
        chk("flush mem_RegWEN", 32'(bus.mem_RegWEN), 32'd0);
        chk("flush dmemWEN", 32'(bus.dmemWEN), 32'd0);
        drive(0, 0, 1, mk(0, 1, 1, 1, 32'h66, 5'd1), '0);
        drive(0, 0, 0, nop, '0);
        chk("flush hold aluout", bus.mem_aluout, 32'h55);
        chk("flush hold RegWEN", 32'(bus.mem_RegWEN), 32'd1);

        // Halt freeze
        drive(1, 0, 0, mk(0, 0, 0, 1, 32'h77, 5'd0), '0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, $urandom_range(0, 1) == 0, rand_op(0), $urandom);
            chk("halt mem_aluout", bus.mem_aluout, 32'h77);
            chk("halt mem_halt", 32'(bus.mem_halt), 32'd1);
        end

        // Reset while a load is outstanding
        do_reset();
        drive(1, 0, 0, mk(1, 1, 0, 0, 32'h100, 5'd2), '0);
        drive(0, 0, 0, nop, '0);
        chk("midload dmemREN", 32'(bus.dmemREN), 32'd1);
        #1 nRST = 1'b0;
        #1 check_all();
        chk("midload rst dmemREN", 32'(bus.dmemREN), 32'd0);
        chk("midload rst stall", 32'(bus.stall_req), 32'd0);
        chk("midload rst aluout", bus.mem_aluout, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Random traffic
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 500; i++) begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 7) == 0, rand_op(1), $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
